// File: rtl/spi_master_engine_if.sv
// Host-side register-bank bus of the SPI master engine.
// spi_loop exists only when SPI_LOOPBACK_EN is defined.
interface spi_master_engine_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned PW  = 4,
  parameter int unsigned NCS = 1
);
  localparam int unsigned LW  = $clog2(DW);
  localparam int unsigned CSW = (NCS > 1) ? $clog2(NCS) : 1;

  logic           spi_start;
  logic           spi_abort;
  logic [LW-1:0]  spi_len;
  logic [PW-1:0]  spi_period;
  logic           spi_cpol;
  logic           spi_cpha;
  logic           spi_lsb_first;
  logic [CSW-1:0] spi_cs_sel;
  logic [DW-1:0]  spi_odata;
`ifdef SPI_LOOPBACK_EN
  logic           spi_loop;
`endif
  logic           spi_busy;
  logic           spi_end;
  logic [DW-1:0]  spi_idata;

  modport master (
`ifdef SPI_LOOPBACK_EN
    output spi_loop,
`endif
    output spi_start, spi_abort, spi_len, spi_period, spi_cpol, spi_cpha,
    output spi_lsb_first, spi_cs_sel, spi_odata,
    input  spi_busy, spi_end, spi_idata
  );

  modport slave (
`ifdef SPI_LOOPBACK_EN
    input  spi_loop,
`endif
    input  spi_start, spi_abort, spi_len, spi_period, spi_cpol, spi_cpha,
    input  spi_lsb_first, spi_cs_sel, spi_odata,
    output spi_busy, spi_end, spi_idata
  );
endinterface

// File: rtl/spi_master_engine.sv
// Parametrised SPI master sequencer: 1..DW bit frames, runtime CPOL/CPHA/bit order/CS.
// Optional feature macro: SPI_LOOPBACK_EN (adds spi_loop, samples SPI_MO internally).
module spi_master_engine #(
  parameter int unsigned DW  = 32,
  parameter int unsigned PW  = 4,
  parameter int unsigned NCS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_master_engine_if.slave   bus,
  input  logic                 SPI_MI,
  output logic                 SPI_CLK,
  output logic                 SPI_MO,
  output logic [NCS-1:0]       SPI_CS_N
);
  localparam int unsigned LW  = $clog2(DW);
  localparam int unsigned CW  = LW + 1;
  localparam int unsigned CSW = (NCS > 1) ? $clog2(NCS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LEAD,
    ST_TRAIL,
    ST_HOLD
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  per_q, per_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [LW-1:0]  len_q, len_d;
  logic           cpol_q, cpol_d;
  logic           cpha_q, cpha_d;
  logic           lsb_q, lsb_d;
  logic [DW-1:0]  tx_q, tx_d;
  logic [DW-1:0]  rx_q, rx_d;
  logic [DW-1:0]  idata_q, idata_d;
  logic           mo_q, mo_d;
  logic           sclk_q, sclk_d;
  logic           busy_q, busy_d;
  logic           end_q, end_d;
  logic [NCS-1:0] cs_n_q, cs_n_d;
  logic           mi_q;

  logic           half_done;
  logic           last_bit;
  logic           sample_en;
  logic           sample_bit;
  logic [LW-1:0]  rx_idx;
  logic [DW-1:0]  rx_next;
  logic [DW-1:0]  tx_load;
  logic [NCS-1:0] cs_sel_n;

  function automatic logic tx_head(input logic [DW-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DW-1];
  endfunction

  function automatic logic [DW-1:0] tx_shift(input logic [DW-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

`ifdef SPI_LOOPBACK_EN
  assign sample_bit = bus.spi_loop ? mo_q : mi_q;
`else
  assign sample_bit = mi_q;
`endif

  // Datapath helpers: half-period timing, receive bit placement, transmit alignment, CS decode.
  always_comb begin
    half_done = (cnt_q == per_q);
    last_bit  = (bit_cnt_q == {1'b0, len_q});
    sample_en = half_done &&
                (cpha_q ? (state_q == ST_TRAIL || state_q == ST_HOLD) : (state_q == ST_LEAD));
    rx_idx    = lsb_q ? bit_cnt_q[LW-1:0] : (len_q - bit_cnt_q[LW-1:0]);
    rx_next   = rx_q;
    if (sample_en) rx_next[rx_idx] = sample_bit;
    // MSB-first frames are left-aligned so the head bit is always tx[DW-1].
    tx_load   = bus.spi_lsb_first ? bus.spi_odata
                                  : (bus.spi_odata << (LW'(DW - 1) - bus.spi_len));
    cs_sel_n  = '1;
    for (int unsigned i = 0; i < NCS; i++) begin
      if (CSW'(i) == bus.spi_cs_sel) cs_sel_n[i] = 1'b0;
    end
  end

  // Next-state and registered-output logic; the last trailing half-period doubles as HOLD.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    bit_cnt_d = bit_cnt_q;
    len_d     = len_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    tx_d      = tx_q;
    rx_d      = rx_next;
    idata_d   = idata_q;
    mo_d      = mo_q;
    sclk_d    = sclk_q;
    busy_d    = busy_q;
    end_d     = 1'b0;
    cs_n_d    = cs_n_q;

    if (state_q != ST_IDLE) cnt_d = half_done ? '0 : cnt_q + PW'(1);

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = bus.spi_cpol;
        if (bus.spi_start && !bus.spi_abort) begin
          state_d   = ST_SETUP;
          cnt_d     = '0;
          bit_cnt_d = '0;
          len_d     = bus.spi_len;
          per_d     = bus.spi_period;
          cpol_d    = bus.spi_cpol;
          cpha_d    = bus.spi_cpha;
          lsb_d     = bus.spi_lsb_first;
          rx_d      = '0;
          busy_d    = 1'b1;
          cs_n_d    = cs_sel_n;
          mo_d      = tx_head(tx_load, bus.spi_lsb_first);
          tx_d      = bus.spi_cpha ? tx_load : tx_shift(tx_load, bus.spi_lsb_first);
        end
      end
      ST_SETUP: begin
        if (half_done) begin
          state_d = ST_LEAD;
          sclk_d  = ~sclk_q;
          if (cpha_q) begin
            mo_d = tx_head(tx_q, lsb_q);
            tx_d = tx_shift(tx_q, lsb_q);
          end
        end
      end
      ST_LEAD: begin
        if (half_done) begin
          sclk_d = ~sclk_q;
          if (last_bit) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_TRAIL;
            if (!cpha_q) begin
              mo_d = tx_head(tx_q, lsb_q);
              tx_d = tx_shift(tx_q, lsb_q);
            end
          end
        end
      end
      ST_TRAIL: begin
        if (half_done) begin
          state_d   = ST_LEAD;
          sclk_d    = ~sclk_q;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (cpha_q) begin
            mo_d = tx_head(tx_q, lsb_q);
            tx_d = tx_shift(tx_q, lsb_q);
          end
        end
      end
      ST_HOLD: begin
        if (half_done) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          end_d   = 1'b1;
          cs_n_d  = '1;
          idata_d = rx_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.spi_abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      end_d   = 1'b0;
      cs_n_d  = '1;
      sclk_d  = cpol_q;
      idata_d = idata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      per_q     <= '0;
      bit_cnt_q <= '0;
      len_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      idata_q   <= '0;
      mo_q      <= 1'b0;
      sclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      end_q     <= 1'b0;
      cs_n_q    <= '1;
      mi_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      bit_cnt_q <= bit_cnt_d;
      len_q     <= len_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      idata_q   <= idata_d;
      mo_q      <= mo_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      end_q     <= end_d;
      cs_n_q    <= cs_n_d;
      mi_q      <= SPI_MI;
    end
  end

  assign SPI_CLK       = sclk_q;
  assign SPI_MO        = mo_q;
  assign SPI_CS_N      = cs_n_q;
  assign bus.spi_busy  = busy_q;
  assign bus.spi_end   = end_q;
  assign bus.spi_idata = idata_q;
endmodule
